// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates ex redirects, external freeze requests and
// load-use hazards into hold/flush strobes, with saturating event counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_req_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic             ex_is_load_i,
    input  logic             cnt_clr_i,
    output logic             jump_o,
    output logic [31:0]      jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             hold_ack_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {RUN, HOLD, RESUME} state_t;

    state_t      state, state_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic [31:0] pend_addr, pend_addr_nxt;
    logic        haz;

    assign haz = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                 ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else begin
            state     <= state_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_addr <= pend_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pend_vld_nxt  = pend_vld;
        pend_addr_nxt = pend_addr;
        jump_o        = 1'b0;
        jump_addr_o   = '0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        hold_ack_o    = 1'b0;

        case (state)
            RUN, RESUME: begin
                state_nxt = RUN;
                if (hold_req_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    if (jump_en_i && !pend_vld) begin
                        pend_vld_nxt  = 1'b1;
                        pend_addr_nxt = jump_addr_i;
                    end
                    state_nxt = HOLD;
                end else if (state == RESUME && pend_vld) begin
                    // Deferred jump wins; the live jump_en_i is the same held instruction.
                    jump_o        = 1'b1;
                    jump_addr_o   = pend_addr;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    pend_vld_nxt  = 1'b0;
                end else if (jump_en_i) begin
                    jump_o        = 1'b1;
                    jump_addr_o   = jump_addr_i;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (haz) begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                end
            end
            HOLD: begin
                hold_pc_o    = 1'b1;
                hold_if_id_o = 1'b1;
                hold_id_ex_o = 1'b1;
                hold_ack_o   = 1'b1;
                if (jump_en_i && !pend_vld) begin
                    pend_vld_nxt  = 1'b1;
                    pend_addr_nxt = jump_addr_i;
                end
                if (!hold_req_i) state_nxt = RESUME;
            end
            default: state_nxt = RUN;
        endcase

        // Outputs follow live inputs, so they must be masked while reset is held.
        if (!rst_n) begin
            jump_o        = 1'b0;
            jump_addr_o   = '0;
            hold_pc_o     = 1'b0;
            hold_if_id_o  = 1'b0;
            hold_id_ex_o  = 1'b0;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
            hold_ack_o    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_pc_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (jump_o && flush_cnt_o != '1)    flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed scoreboard bench for pipe_ctrl (CNT_W=16 and CNT_W=4 instances).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_req;
    logic [4:0]  rs1, rs2, rd;
    logic        wen, is_load, cnt_clr;

    logic        j_a, hpc_a, hif_a, hex_a, fif_a, fex_a, ack_a;
    logic [31:0] ja_a;
    logic [15:0] sc_a, fc_a;
    logic        j_b, hpc_b, hif_b, hex_b, fif_b, fex_b, ack_b;
    logic [31:0] ja_b;
    logic [3:0]  sc_b, fc_b;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .hold_req_i(hold_req), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(is_load), .cnt_clr_i(cnt_clr),
        .jump_o(j_a), .jump_addr_o(ja_a), .hold_pc_o(hpc_a), .hold_if_id_o(hif_a),
        .hold_id_ex_o(hex_a), .flush_if_id_o(fif_a), .flush_id_ex_o(fex_a),
        .hold_ack_o(ack_a), .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
        .hold_req_i(hold_req), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .ex_rd_addr_i(rd), .ex_reg_wen_i(wen), .ex_is_load_i(is_load), .cnt_clr_i(cnt_clr),
        .jump_o(j_b), .jump_addr_o(ja_b), .hold_pc_o(hpc_b), .hold_if_id_o(hif_b),
        .hold_id_ex_o(hex_b), .flush_if_id_o(fif_b), .flush_id_ex_o(fex_b),
        .hold_ack_o(ack_b), .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
    );

    typedef struct packed {
        logic        jump;
        logic [31:0] addr;
        logic        hpc, hif, hex, fif, fex, ack;
    } ctrl_t;

    typedef struct packed {
        logic [15:0] stall, flush;
        logic [3:0]  stall4, flush4;
    } cnt_t;

    ctrl_t exp_ctrl_q[$];
    cnt_t  exp_cnt_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: phase 0 = running, 1 = frozen, 2 = first cycle after release.
    int          m_phase;
    bit          m_pend;
    logic [31:0] m_pend_addr;
    longint      m_stalls, m_jumps;

    function automatic longint sat(longint v, longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pend = 0; m_pend_addr = '0; m_stalls = 0; m_jumps = 0;
    endtask

    task automatic step(input bit r, input bit je, input logic [31:0] ja, input bit hr,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input bit w, input bit ld, input bit clr);
        ctrl_t  e;
        cnt_t   c;
        bit     hz;
        @(posedge clk);
        #1;
        rst_n = r; jump_en = je; jump_addr = ja; hold_req = hr;
        rs1 = a1; rs2 = a2; rd = d; wen = w; is_load = ld; cnt_clr = clr;
        e = '0;
        if (!r) begin
            model_reset();
            c = '0;
        end else begin
            c.stall  = 16'(sat(m_stalls, 65535));
            c.flush  = 16'(sat(m_jumps, 65535));
            c.stall4 = 4'(sat(m_stalls, 15));
            c.flush4 = 4'(sat(m_jumps, 15));
            hz = ld && w && d != 0 && (d == a1 || d == a2);
            if (m_phase == 1 || hr) begin
                e.hpc = 1; e.hif = 1; e.hex = 1;
                e.ack = (m_phase == 1);
                if (je && !m_pend) begin m_pend = 1; m_pend_addr = ja; end
                m_phase = hr ? 1 : 2;
            end else if (m_phase == 2 && m_pend) begin
                e.jump = 1; e.addr = m_pend_addr; e.fif = 1; e.fex = 1;
                m_pend = 0; m_phase = 0;
            end else begin
                m_phase = 0;
                if (je) begin
                    e.jump = 1; e.addr = ja; e.fif = 1; e.fex = 1;
                end else if (hz) begin
                    e.hpc = 1; e.hif = 1; e.fex = 1;
                end
            end
            if (clr) begin
                m_stalls = 0; m_jumps = 0;
            end else begin
                m_stalls += e.hpc;
                m_jumps  += e.jump;
            end
        end
        exp_ctrl_q.push_back(e);
        exp_cnt_q.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; sample on the falling edge.
    always @(negedge clk) begin
        ctrl_t ga, gb, ec;
        cnt_t  gc, ecn;
        if (exp_ctrl_q.size() > 0) begin
            ec  = exp_ctrl_q.pop_front();
            ecn = exp_cnt_q.pop_front();
            ga  = '{j_a, ja_a, hpc_a, hif_a, hex_a, fif_a, fex_a, ack_a};
            gb  = '{j_b, ja_b, hpc_b, hif_b, hex_b, fif_b, fex_b, ack_b};
            gc  = '{sc_a, fc_a, sc_b, fc_b};
            n_checks++;
            if (ga === ec && gb === ec) n_pass++;
            else $display("FAIL ctrl @%0t: got16=%h got4=%h expected=%h", $time, ga, gb, ec);
            n_checks++;
            if (gc === ecn) n_pass++;
            else $display("FAIL counters @%0t: got=%h expected=%h", $time, gc, ecn);
        end
    end

    initial begin
        rst_n = 0; jump_en = 0; jump_addr = '0; hold_req = 0;
        rs1 = '0; rs2 = '0; rd = '0; wen = 0; is_load = 0; cnt_clr = 0;
        model_reset();

        // Load-use hazard, then same with rd=0.
        do_reset();
        step(1, 0, 0, 0, 5'd5, 0, 5'd5, 1, 1, 0);
        idle(2);
        step(1, 0, 0, 0, 5'd5, 0, 5'd0, 1, 1, 0);
        idle(1);

        // Jump masks a simultaneous hazard.
        do_reset();
        step(1, 1, 32'h100, 0, 5'd5, 0, 5'd5, 1, 1, 0);
        idle(2);

        // Hold cycles 0-3, jumps 0x200 then 0x300 while frozen.
        do_reset();
        step(1, 0, 0,       1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h200, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h300, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0,       1, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Hold re-asserted in the release cycle with a pending jump.
        do_reset();
        step(1, 1, 32'h400, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h444, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Saturation on the 4-bit instance, then clear under an active hazard.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 5'd3, 5'd7, 5'd7, 1, 1, 0);
        step(1, 0, 0, 0, 5'd3, 5'd7, 5'd7, 1, 1, 1);
        step(1, 0, 0, 0, 5'd3, 5'd7, 5'd7, 1, 1, 0);
        idle(1);

        // Reset during HOLD with a pending jump.
        do_reset();
        step(1, 1, 32'h500, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h600, 1, 5'd1, 0, 5'd1, 1, 1, 0);
        idle(4);

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 3),
                 $urandom(),
                 ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 63) == 0));
        end
        idle(1);

        repeat (3) @(posedge clk);
        if (exp_ctrl_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, required 0", exp_ctrl_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 3-stage core (pc_reg → if_id → id → id_ex → ex).
- Arbitrates three competing control events: ex-stage jump/branch redirect, external multi-cycle hold request (bus/peripheral wait), and id-stage load-use RAW hazard.
- Drives hold/flush strobes to pc_reg, if_id, id_ex and the redirect to pc_reg, defers jumps that arrive while the pipeline is frozen, and keeps saturating performance counters.

Parameters:
- CNT_W, 16, width of stall_cnt_o and flush_cnt_o.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- jump_en_i  in  1  ex requests redirect this cycle
- jump_addr_i  in  32  ex redirect target
- hold_req_i  in  1  external freeze request, level
- id_rs1_addr_i  in  5  rs1_addr_o from id (0 = unused)
- id_rs2_addr_i  in  5  rs2_addr_o from id (0 = unused)
- ex_rd_addr_i  in  5  destination of instruction in ex
- ex_reg_wen_i  in  1  ex instruction writes rd
- ex_is_load_i  in  1  ex instruction is a load
- cnt_clr_i  in  1  synchronous counter clear
- jump_o  out  1  redirect strobe to pc_reg
- jump_addr_o  out  32  redirect target to pc_reg
- hold_pc_o  out  1  pc_reg keeps value
- hold_if_id_o  out  1  if_id keeps value
- hold_id_ex_o  out  1  id_ex keeps value
- flush_if_id_o  out  1  if_id loads NOP (0x00000013)
- flush_id_ex_o  out  1  id_ex loads NOP
- hold_ack_o  out  1  pipeline fully frozen
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o=1, saturating
- flush_cnt_o  out  CNT_W  jumps issued, saturating

Behaviour:
- Reset (rst_n=0, async): state=RUN, pend_vld=0, pend_addr=0, both counters=0; all 1-bit outputs 0, jump_addr_o=0.
- States: RUN, HOLD, RESUME. Outputs are combinational from state, pend_* and inputs; state/pend/counters are registered.
- haz = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i!=0) & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
- RUN, priority hold_req_i > jump_en_i > haz:
  - hold_req_i=1: hold_pc/hold_if_id/hold_id_ex=1, no jump issued, no flush. If jump_en_i=1, latch pend_vld=1, pend_addr=jump_addr_i. Next state HOLD.
  - Otherwise, jump_en_i=1: jump_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=flush_id_ex_o=1, no holds (haz masked). Stay RUN.
  - Otherwise, haz=1: hold_pc_o=hold_if_id_o=1, flush_id_ex_o=1 (exactly one bubble; the next cycle's ex holds a NOP, so haz self-clears). Stay RUN.
  - Otherwise, all strobes 0.
- HOLD:
  - hold_pc/hold_if_id/hold_id_ex=1 and hold_ack_o=1 every cycle.
  - jump_en_i=1 with pend_vld=0 latches pend; if pend_vld=1, the first latched jump is kept.
  - hold_req_i=0 → RESUME at next edge (release latency 1 cycle).
- RESUME (one cycle):
  - hold_req_i=1: holds=1, no issue, pend kept, → HOLD.
  - Else, pend_vld=1: jump_o=1, jump_addr_o=pend_addr, both flushes=1, pend_vld cleared; jump_en_i ignored this cycle (same held instruction); → RUN.
  - Else: behave exactly as RUN (jump/haz rules apply); → RUN.
- jump_addr_o = 0 whenever jump_o=0.
- Counters:
  - stall_cnt +1 on each cycle with hold_pc_o=1; flush_cnt +1 on each cycle with jump_o=1.
  - Both saturate at all-ones.
  - cnt_clr_i=1 forces both to 0 next edge and overrides increments.
- Reset mid-HOLD discards pend and returns to RUN immediately (async).

Test Plan:
- Reset, then id_rs1=5, ex_rd=5, ex_is_load=1, ex_reg_wen=1 for 1 cycle → hold_pc=hold_if_id=flush_id_ex=1 in that cycle only; stall_cnt=1.
- Same as above but ex_rd=0 → no strobes.
- RUN, jump_en=1, jump_addr=0x0000_0100, haz also true → jump_o=1, addr 0x100, both flushes=1, no holds; flush_cnt=1.
- hold_req high for cycles 0-3, jump_en with 0x200 at cycle 1 and 0x300 at cycle 2:
  - hold_ack=1 in cycles 1-4.
  - Cycle 5 (RESUME): jump_o=1, addr 0x200; 0x300 is never issued.
  - stall_cnt=5.
- hold_req re-asserted in the RESUME cycle with pend valid → no jump; back to HOLD; after the final release, jump issued exactly once.
- CNT_W=4: 20 hazard cycles → stall_cnt=15 (saturated); cnt_clr=1 → 0 on the next cycle even while the hazard is active.
- Reset pulse during HOLD with pend valid → all outputs 0 immediately; no jump issued after reset release.
